// File: rtl/rc_adder_pkg.sv
// ----------------------------------------------------------------------------
// rc_adder_pkg
// Shared definitions for the ripple-carry adder and the blocks that integrate it.
//   RC_ADDER_DEFAULT_WIDTH : default operand width
//   rc_adder_result_t      : {carry, sum} result at the default width
//   rc_adder_pack()        : builds a result struct from carry and sum
// Optional feature macro used elsewhere in this slice: RC_ADDER_OVF_EN.
// ----------------------------------------------------------------------------
package rc_adder_pkg;

    localparam int RC_ADDER_DEFAULT_WIDTH = 4;

    // Exact (WIDTH+1)-bit unsigned result. The carry is the MSB, so the
    // packed struct can be compared directly against an integer sum.
    typedef struct packed {
        logic                              carry;
        logic [RC_ADDER_DEFAULT_WIDTH-1:0] sum;
    } rc_adder_result_t;

    function automatic rc_adder_result_t rc_adder_pack(
        input logic                              carry,
        input logic [RC_ADDER_DEFAULT_WIDTH-1:0] sum
    );
        rc_adder_result_t res;
        res.carry = carry;
        res.sum   = sum;
        return res;
    endfunction

endpackage

// File: rtl/rc_adder_if.sv
// ----------------------------------------------------------------------------
// rc_adder_if
// Operand/result bundle between an rc_adder and the block that uses it.
//   in_valid, a, b, c_in : operand side, driven by the master
//   out_valid, sum, c_out: registered result side, driven by the adder
//   ovf                  : signed overflow flag, only when RC_ADDER_OVF_EN
// Modports: master (operand source / result sink), slave (the adder).
// ----------------------------------------------------------------------------
interface rc_adder_if
    import rc_adder_pkg::*;
#(
    parameter int WIDTH = RC_ADDER_DEFAULT_WIDTH
);

    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             out_valid;
    logic [WIDTH-1:0] sum;
    logic             c_out;
`ifdef RC_ADDER_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, c_in,
`ifdef RC_ADDER_OVF_EN
        input  ovf,
`endif
        input  out_valid, sum, c_out
    );

    modport slave (
        input  in_valid, a, b, c_in,
`ifdef RC_ADDER_OVF_EN
        output ovf,
`endif
        output out_valid, sum, c_out
    );

endinterface

// File: rtl/rc_adder_full_adder.sv
// ----------------------------------------------------------------------------
// full_adder
// Single-bit combinational full adder, the cell of the ripple chain.
//   a, b : operand bits
//   cin  : carry in
//   s    : sum bit  = a ^ b ^ cin
//   cout : carry out = generate | (propagate & cin)
// ----------------------------------------------------------------------------
module full_adder
    import rc_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic prop;

    assign prop = a ^ b;
    assign s    = prop ^ cin;
    assign cout = (a & b) | (prop & cin);

endmodule

// File: rtl/rc_adder.sv
// ----------------------------------------------------------------------------
// rc_adder
// Parameterised ripple-carry adder with a one-cycle registered, valid-qualified
// result: {c_out, sum} = a + b + c_in (exact, never overflows).
// Parameters:
//   WIDTH : operand/sum width, 1..64
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (clears sum, c_out, out_valid)
//   bus   : rc_adder_if.slave (in_valid, a, b, c_in -> out_valid, sum, c_out)
// Optional feature: define RC_ADDER_OVF_EN to add the registered two's
// complement overflow flag bus.ovf; without it no overflow logic exists.
// ----------------------------------------------------------------------------
module rc_adder
    import rc_adder_pkg::*;
#(
    parameter int WIDTH = RC_ADDER_DEFAULT_WIDTH
) (
    input  logic       clk,
    input  logic       rst_n,
    rc_adder_if.slave  bus
);

    // carry[i] is the carry into bit i; carry[WIDTH] is the final carry out.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] s_comb;

    logic             valid_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             c_out_reg;

    assign carry[0] = bus.c_in;

    // Strict bit-serial carry chain: each cell waits on its neighbour below.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
            full_adder u_fa (
                .a    (bus.a[gi]),
                .b    (bus.b[gi]),
                .cin  (carry[gi]),
                .s    (s_comb[gi]),
                .cout (carry[gi+1])
            );
        end
    endgenerate

    // out_valid follows in_valid every cycle; the data registers only load on
    // a valid operand so garbage (including X) on idle cycles never leaks out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            sum_reg   <= '0;
            c_out_reg <= 1'b0;
        end else begin
            valid_reg <= bus.in_valid;
            if (bus.in_valid) begin
                sum_reg   <= s_comb;
                c_out_reg <= carry[WIDTH];
            end
        end
    end

    assign bus.out_valid = valid_reg;
    assign bus.sum       = sum_reg;
    assign bus.c_out     = c_out_reg;

`ifdef RC_ADDER_OVF_EN
    // Signed overflow: carry into the sign bit differs from carry out of it.
    // For WIDTH=1 the carry into the sign bit is c_in itself.
    logic ovf_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_reg <= 1'b0;
        end else if (bus.in_valid) begin
            ovf_reg <= carry[WIDTH] ^ carry[WIDTH-1];
        end
    end

    assign bus.ovf = ovf_reg;
`endif

endmodule

// File: tb/tb_rc_adder.sv
// ----------------------------------------------------------------------------
// tb_rc_adder
// Two adders (WIDTH=4 and WIDTH=16) driven through rc_adder_if. An arithmetic
// reference model predicts the registered outputs; a compare process checks
// them on every falling edge out of reset. Directed vectors with literal
// results pin the model, then a randomised run with a mid-stream reset.
// ----------------------------------------------------------------------------
module tb_rc_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    rc_adder_if #(.WIDTH(4))  if4 ();
    rc_adder_if #(.WIDTH(16)) if16 ();

    rc_adder #(.WIDTH(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if4.slave)
    );

    rc_adder #(.WIDTH(16)) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if16.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

`ifdef RC_ADDER_OVF_EN
    // Signed overflow: exact signed sum falls outside the w-bit range.
    function automatic logic ovf_of(input logic [63:0] a, input logic [63:0] b,
                                    input logic cin, input int w);
        longint sa, sb, tot, lim;
        lim = longint'(1) << (w - 1);
        sa  = longint'(a);
        sb  = longint'(b);
        if (a[w-1]) sa = sa - (lim << 1);
        if (b[w-1]) sb = sb - (lim << 1);
        tot = sa + sb + longint'(cin);
        return (tot > lim - 1) || (tot < -lim);
    endfunction
`endif

    // Reference model: result = exact integer sum, captured when valid.
    logic        m4_valid  = 1'b0;
    logic [4:0]  m4_res    = '0;
    logic        m16_valid = 1'b0;
    logic [16:0] m16_res   = '0;
`ifdef RC_ADDER_OVF_EN
    logic        m4_ovf    = 1'b0;
    logic        m16_ovf   = 1'b0;
`endif

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m4_valid  <= 1'b0;
            m4_res    <= '0;
            m16_valid <= 1'b0;
            m16_res   <= '0;
`ifdef RC_ADDER_OVF_EN
            m4_ovf    <= 1'b0;
            m16_ovf   <= 1'b0;
`endif
        end else begin
            m4_valid  <= if4.in_valid;
            m16_valid <= if16.in_valid;
            if (if4.in_valid) begin
                m4_res <= {1'b0, if4.a} + {1'b0, if4.b} + 5'(if4.c_in);
`ifdef RC_ADDER_OVF_EN
                m4_ovf <= ovf_of(64'(if4.a), 64'(if4.b), if4.c_in, 4);
`endif
            end
            if (if16.in_valid) begin
                m16_res <= {1'b0, if16.a} + {1'b0, if16.b} + 17'(if16.c_in);
`ifdef RC_ADDER_OVF_EN
                m16_ovf <= ovf_of(64'(if16.a), 64'(if16.b), if16.c_in, 16);
`endif
            end
        end
    end

    // Compare process: every falling edge while out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            cmp("valid4", 64'(if4.out_valid), 64'(m4_valid));
            cmp("result4", 64'({if4.c_out, if4.sum}), 64'(m4_res));
            cmp("valid16", 64'(if16.out_valid), 64'(m16_valid));
            cmp("result16", 64'({if16.c_out, if16.sum}), 64'(m16_res));
`ifdef RC_ADDER_OVF_EN
            cmp("ovf4", 64'(if4.ovf), 64'(m4_ovf));
            cmp("ovf16", 64'(if16.ovf), 64'(m16_ovf));
`endif
        end
    end

    // Directed WIDTH=4 vectors with hand-computed results.
    localparam int ND = 8;
    logic [3:0] da [ND] = '{4'h0, 4'h6, 4'h8, 4'hC, 4'hF, 4'hF, 4'hF, 4'h7};
    logic [3:0] db [ND] = '{4'h0, 4'h8, 4'h2, 4'hC, 4'h3, 4'h0, 4'hF, 4'h0};
    logic       dc [ND] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [3:0] es [ND] = '{4'h0, 4'hF, 4'hB, 4'h9, 4'h3, 4'h0, 4'hF, 4'h8};
    logic       ec [ND] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`ifdef RC_ADDER_OVF_EN
    logic       eo [ND] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`endif

    initial begin
        if4.in_valid  = 1'b0; if4.a  = '0; if4.b  = '0; if4.c_in  = 1'b0;
        if16.in_valid = 1'b0; if16.a = '0; if16.b = '0; if16.c_in = 1'b0;

        // Reset state.
        @(posedge clk); #2;
        cmp("rst_valid4", 64'(if4.out_valid), 64'd0);
        cmp("rst_sum4", 64'(if4.sum), 64'd0);
        cmp("rst_cout4", 64'(if4.c_out), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Back-to-back directed stream; result i checked one cycle after drive.
        for (int i = 0; i <= ND; i++) begin
            @(posedge clk); #1;
            if (i > 0) begin
                cmp($sformatf("dir%0d_valid", i - 1), 64'(if4.out_valid), 64'd1);
                cmp($sformatf("dir%0d_sum", i - 1), 64'(if4.sum), 64'(es[i-1]));
                cmp($sformatf("dir%0d_cout", i - 1), 64'(if4.c_out), 64'(ec[i-1]));
                cmp($sformatf("dir%0d_model", i - 1), 64'(m4_res), 64'({ec[i-1], es[i-1]}));
`ifdef RC_ADDER_OVF_EN
                cmp($sformatf("dir%0d_ovf", i - 1), 64'(if4.ovf), 64'(eo[i-1]));
`endif
            end
            if (i < ND) begin
                if4.in_valid = 1'b1;
                if4.a = da[i]; if4.b = db[i]; if4.c_in = dc[i];
            end else begin
                if4.in_valid = 1'b0;
                if4.a = 'x; if4.b = 'x; if4.c_in = 1'bx;
            end
        end

        // Idle with undefined operands: valid drops, last result (7+0+1) holds.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            cmp("hold_valid", 64'(if4.out_valid), 64'd0);
            cmp("hold_sum", 64'(if4.sum), 64'h8);
            cmp("hold_cout", 64'(if4.c_out), 64'd0);
            if4.a = 4'($urandom); if4.b = 4'($urandom);
        end

        // Randomised run on both widths, with a reset asserted mid-stream.
        for (int i = 0; i < 10000; i++) begin
            @(posedge clk); #1;
            if4.in_valid  = ($urandom_range(0, 9) != 0);
            if4.a         = 4'($urandom);
            if4.b         = 4'($urandom);
            if4.c_in      = 1'($urandom);
            if16.in_valid = ($urandom_range(0, 9) != 0);
            if16.a        = 16'($urandom);
            if16.b        = 16'($urandom);
            if16.c_in     = 1'($urandom);
            if (i == 5000) begin
                if4.in_valid  = 1'b1;
                if16.in_valid = 1'b1;
                #3;
                rst_n = 1'b0;
                #1;
                cmp("mid_rst_valid4", 64'(if4.out_valid), 64'd0);
                cmp("mid_rst_sum4", 64'(if4.sum), 64'd0);
                cmp("mid_rst_cout4", 64'(if4.c_out), 64'd0);
                cmp("mid_rst_valid16", 64'(if16.out_valid), 64'd0);
                cmp("mid_rst_sum16", 64'(if16.sum), 64'd0);
                cmp("mid_rst_cout16", 64'(if16.c_out), 64'd0);
                @(posedge clk); #1;
                rst_n = 1'b1;
            end
        end

        @(posedge clk); #1;
        if4.in_valid  = 1'b0;
        if16.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
